axil_cfg_master: RTL and testbench
==================================

AXIL_CFG_MASTER -- requirements
Module: axil_cfg_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max wait cycles per transaction phase before abort (1..2^TIMEOUT_W-1).
REQ-002 SHALL have parameter TIMEOUT_W, default 8: timeout counter width.
REQ-003 SHALL have ports, clock and reset first (name  direction  width  meaning):
- clk_i  in  1  sole clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- req_valid_i  in  1  command request
- req_ready_o  out  1  command accepted when both high
- req_write_i  in  1  1=write, 0=read
- req_addr_i  in  32  target byte address
- req_wdata_i  in  32  write data
- req_wstrb_i  in  4  write byte strobes
- resp_valid_o  out  1  completion available
- resp_ready_i  in  1  completion consumed when both high
- resp_rdata_o  out  32  read data (0 for writes/timeouts)
- resp_resp_o  out  2  captured BRESP/RRESP (0 on timeout)
- resp_timeout_o  out  1  transaction aborted by timeout
- cfg_awvalid_o, cfg_awaddr_o[31:0], cfg_wvalid_o, cfg_wdata_o[31:0], cfg_wstrb_o[3:0], cfg_bready_o, cfg_arvalid_o, cfg_araddr_o[31:0], cfg_rready_o  out  AXI4-Lite master channels
- cfg_awready_i, cfg_wready_i, cfg_bvalid_i, cfg_bresp_i[1:0], cfg_arready_i, cfg_rvalid_i, cfg_rdata_i[31:0], cfg_rresp_i[1:0]  in  AXI4-Lite slave returns

Function
REQ-004 SHALL implement FSM states IDLE, WRITE, WRESP, READ, RDATA, RESP; one transaction outstanding at most.
REQ-005 req_ready_o SHALL equal (state==IDLE); accept registers addr/wdata/wstrb/write into holding regs.
REQ-006 IDLE + accepted write -> WRITE next cycle with cfg_awvalid_o=cfg_wvalid_o=1; accepted read -> READ with cfg_arvalid_o=1.
REQ-007 In WRITE, AW and W SHALL complete independently: each valid drops the cycle after its own handshake; both done (same or different cycles) -> WRESP.
REQ-008 In WRESP, cfg_bready_o=1; on cfg_bvalid_i capture cfg_bresp_i into resp_resp_o -> RESP.
REQ-009 In READ, cfg_arvalid_o held until cfg_arready_i -> RDATA; in RDATA cfg_rready_o=1, on cfg_rvalid_i capture cfg_rdata_i/cfg_rresp_i -> RESP.
REQ-010 cfg_*addr/wdata/wstrb outputs SHALL be driven from holding regs and stable while corresponding valid high.
REQ-011 In RESP, resp_valid_o=1 and outputs stable until resp_ready_i; then -> IDLE; req_ready_o SHALL go high no earlier than cycle after resp handshake.
REQ-012 Latency with zero-wait slave: req handshake cycle N, AW/W/AR handshake N+1, B/R handshake N+2, resp_valid_o high N+3.
REQ-013 Timeout counter SHALL clear on every state change and increment each cycle in WRITE/WRESP/READ/RDATA; saturates, no wrap.
REQ-014 Counter reaching TIMEOUT SHALL, next cycle, deassert all cfg valids/readies, set resp_timeout_o=1, resp_resp_o=0, resp_rdata_o=0 -> RESP; a handshake in the same cycle as expiry wins over the timeout.
REQ-015 resp_rdata_o SHALL be 0 for writes; resp_timeout_o SHALL be 0 on normal completion.
REQ-016 cfg_bvalid_i/cfg_rvalid_i outside WRESP/RDATA SHALL be ignored (ready low).

Reset
REQ-017 rst_i high on clock edge SHALL force IDLE, counter 0, all cfg valid/ready outputs 0, resp_valid_o 0, resp_rdata_o 0, resp_resp_o 0, resp_timeout_o 0, holding regs 0; reset mid-transaction abandons it without response.
REQ-018 req_ready_o SHALL be 1 in the first cycle after rst_i deasserts.

Verification
REQ-019 Write 0x10, data 0xA5A5_0001, strb 0xF, zero-wait slave -> AW/W handshake N+1, bready N+2, resp_valid_o N+3, resp_resp_o=0, rdata=0.
REQ-020 Write with awready 3 cycles before wready -> awvalid drops after AW, wvalid held until W, single WRESP entry, one response.
REQ-021 Read 0x20, slave returns 0xDEAD_BEEF rresp=2 after 5 wait cycles -> resp_rdata_o=0xDEAD_BEEF, resp_resp_o=2, timeout 0.
REQ-022 TIMEOUT=4, slave never asserts arready -> arvalid drops after 4 wait cycles, resp_valid_o with resp_timeout_o=1, rdata=0.
REQ-023 resp_ready_i held low 10 cycles, req_valid_i high -> req_ready_o stays 0, resp outputs stable; second request accepted cycle after resp handshake.
REQ-024 rst_i asserted while in WRESP -> next cycle all outputs reset values, no resp_valid_o, req_ready_o=1 after release.

Source files
------------

// File: rtl/axil_cfg_master.sv
// Single-outstanding AXI4-Lite config master: request in, one AXI-Lite transaction, one response out.
// Zero-wait slave: req N, AW/W/AR N+1, B/R N+2, resp_valid N+3; new requests stall until the response is consumed.
module axil_cfg_master #(
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_wstrb_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic [1:0]  resp_resp_o,
  output logic        resp_timeout_o,
  output logic        cfg_awvalid_o,
  output logic [31:0] cfg_awaddr_o,
  output logic        cfg_wvalid_o,
  output logic [31:0] cfg_wdata_o,
  output logic [3:0]  cfg_wstrb_o,
  output logic        cfg_bready_o,
  output logic        cfg_arvalid_o,
  output logic [31:0] cfg_araddr_o,
  output logic        cfg_rready_o,
  input  logic        cfg_awready_i,
  input  logic        cfg_wready_i,
  input  logic        cfg_bvalid_i,
  input  logic [1:0]  cfg_bresp_i,
  input  logic        cfg_arready_i,
  input  logic        cfg_rvalid_i,
  input  logic [31:0] cfg_rdata_i,
  input  logic [1:0]  cfg_rresp_i
);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, RESP} state_t;

  // The abort fires in the cycle the counter would step onto TIMEOUT, so a
  // phase can wait at most TIMEOUT cycles with its valid/ready asserted.
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] CNT_MAX  = {TIMEOUT_W{1'b1}};

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           wstrb_q, wstrb_d;
  logic                 awvalid_q, awvalid_d;
  logic                 wvalid_q, wvalid_d;
  logic                 bready_q, bready_d;
  logic                 arvalid_q, arvalid_d;
  logic                 rready_q, rready_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [1:0]           resp_q, resp_d;
  logic                 timeout_q, timeout_d;
  logic                 expire;
  logic                 abort;
  logic                 counting;

  assign expire   = (cnt_q >= CNT_LAST);
  assign counting = (state_q == WRITE) || (state_q == WRESP) ||
                    (state_q == READ)  || (state_q == RDATA);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    resp_d       = resp_q;
    timeout_d    = timeout_q;
    abort        = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          wstrb_d = req_wstrb_i;
          if (req_write_i) begin
            state_d   = WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = READ;
            arvalid_d = 1'b1;
          end
        end
      end
      WRITE: begin
        // Each valid doubles as its channel's "still pending" flag.
        awvalid_d = awvalid_q & ~cfg_awready_i;
        wvalid_d  = wvalid_q & ~cfg_wready_i;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WRESP;
          bready_d = 1'b1;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      WRESP: begin
        if (cfg_bvalid_i) begin
          state_d      = RESP;
          bready_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_d       = cfg_bresp_i;
          rdata_d      = '0;
          timeout_d    = 1'b0;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      READ: begin
        if (cfg_arready_i) begin
          state_d   = RDATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      RDATA: begin
        if (cfg_rvalid_i) begin
          state_d      = RESP;
          rready_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_d       = cfg_rresp_i;
          rdata_d      = cfg_rdata_i;
          timeout_d    = 1'b0;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d      = RESP;
      awvalid_d    = 1'b0;
      wvalid_d     = 1'b0;
      bready_d     = 1'b0;
      arvalid_d    = 1'b0;
      rready_d     = 1'b0;
      resp_valid_d = 1'b1;
      timeout_d    = 1'b1;
      resp_d       = '0;
      rdata_d      = '0;
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (counting && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      resp_q       <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      resp_q       <= resp_d;
      timeout_q    <= timeout_d;
    end
  end

  assign req_ready_o    = (state_q == IDLE);
  assign resp_valid_o   = resp_valid_q;
  assign resp_rdata_o   = rdata_q;
  assign resp_resp_o    = resp_q;
  assign resp_timeout_o = timeout_q;
  assign cfg_awvalid_o  = awvalid_q;
  assign cfg_awaddr_o   = addr_q;
  assign cfg_wvalid_o   = wvalid_q;
  assign cfg_wdata_o    = wdata_q;
  assign cfg_wstrb_o    = wstrb_q;
  assign cfg_bready_o   = bready_q;
  assign cfg_arvalid_o  = arvalid_q;
  assign cfg_araddr_o   = addr_q;
  assign cfg_rready_o   = rready_q;

endmodule

// File: tb/tb_axil_cfg_master.sv
// Directed bench for axil_cfg_master: default instance for protocol/latency, TIMEOUT=4 instance for abort.
module tb_axil_cfg_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_main, rst_to;
  logic        req_valid, req_write, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  logic        m_req_ready, m_resp_valid, m_resp_timeout, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [31:0] m_resp_rdata, m_awaddr, m_wdata, m_araddr;
  logic [1:0]  m_resp_resp;
  logic [3:0]  m_wstrb;

  logic        t_req_ready, t_resp_valid, t_resp_timeout, t_awvalid, t_wvalid, t_bready, t_arvalid, t_rready;
  logic [31:0] t_resp_rdata, t_awaddr, t_wdata, t_araddr;
  logic [1:0]  t_resp_resp;
  logic [3:0]  t_wstrb;

  int n_checks = 0;
  int n_fail   = 0;

  axil_cfg_master u_dut (
    .clk_i(clk), .rst_i(rst_main),
    .req_valid_i(req_valid), .req_ready_o(m_req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .resp_valid_o(m_resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(m_resp_rdata),
    .resp_resp_o(m_resp_resp), .resp_timeout_o(m_resp_timeout),
    .cfg_awvalid_o(m_awvalid), .cfg_awaddr_o(m_awaddr), .cfg_wvalid_o(m_wvalid),
    .cfg_wdata_o(m_wdata), .cfg_wstrb_o(m_wstrb), .cfg_bready_o(m_bready),
    .cfg_arvalid_o(m_arvalid), .cfg_araddr_o(m_araddr), .cfg_rready_o(m_rready),
    .cfg_awready_i(awready), .cfg_wready_i(wready), .cfg_bvalid_i(bvalid), .cfg_bresp_i(bresp),
    .cfg_arready_i(arready), .cfg_rvalid_i(rvalid), .cfg_rdata_i(rdata), .cfg_rresp_i(rresp)
  );

  axil_cfg_master #(.TIMEOUT(4), .TIMEOUT_W(8)) u_dut_to (
    .clk_i(clk), .rst_i(rst_to),
    .req_valid_i(req_valid), .req_ready_o(t_req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .resp_valid_o(t_resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(t_resp_rdata),
    .resp_resp_o(t_resp_resp), .resp_timeout_o(t_resp_timeout),
    .cfg_awvalid_o(t_awvalid), .cfg_awaddr_o(t_awaddr), .cfg_wvalid_o(t_wvalid),
    .cfg_wdata_o(t_wdata), .cfg_wstrb_o(t_wstrb), .cfg_bready_o(t_bready),
    .cfg_arvalid_o(t_arvalid), .cfg_araddr_o(t_araddr), .cfg_rready_o(t_rready),
    .cfg_awready_i(awready), .cfg_wready_i(wready), .cfg_bvalid_i(bvalid), .cfg_bresp_i(bresp),
    .cfg_arready_i(arready), .cfg_rvalid_i(rvalid), .cfg_rdata_i(rdata), .cfg_rresp_i(rresp)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
  endtask

  initial begin
    rst_main = 1'b1; rst_to = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    resp_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;

    // Reset state
    tick(); tick();
    chk("rst_resp_valid", 32'(m_resp_valid), 32'd0);
    chk("rst_awvalid", 32'(m_awvalid), 32'd0);
    chk("rst_arvalid", 32'(m_arvalid), 32'd0);
    chk("rst_rdata", m_resp_rdata, 32'd0);
    rst_main = 1'b0;
    tick();
    chk("post_rst_req_ready", 32'(m_req_ready), 32'd1);

    // Zero-wait write
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'd0;
    req(1'b1, 32'h10, 32'hA5A5_0001, 4'hF);
    chk("w0_req_ready_N", 32'(m_req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk("w0_awvalid_N1", 32'(m_awvalid), 32'd1);
    chk("w0_wvalid_N1", 32'(m_wvalid), 32'd1);
    chk("w0_awaddr", m_awaddr, 32'h10);
    chk("w0_wdata", m_wdata, 32'hA5A5_0001);
    chk("w0_wstrb", 32'(m_wstrb), 32'hF);
    tick();
    chk("w0_awvalid_N2", 32'(m_awvalid), 32'd0);
    chk("w0_bready_N2", 32'(m_bready), 32'd1);
    tick();
    chk("w0_resp_valid_N3", 32'(m_resp_valid), 32'd1);
    chk("w0_resp", 32'(m_resp_resp), 32'd0);
    chk("w0_rdata", m_resp_rdata, 32'd0);
    chk("w0_timeout", 32'(m_resp_timeout), 32'd0);
    chk("w0_req_ready_resp", 32'(m_req_ready), 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("w0_resp_done", 32'(m_resp_valid), 32'd0);
    chk("w0_idle_ready", 32'(m_req_ready), 32'd1);

    // Write with AW accepted three cycles before W
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    req(1'b1, 32'h14, 32'h1234_5678, 4'h3);
    tick();
    req_valid = 1'b0;
    awready = 1'b1;
    chk("w1_awvalid_N1", 32'(m_awvalid), 32'd1);
    tick();
    awready = 1'b0;
    chk("w1_awvalid_drop", 32'(m_awvalid), 32'd0);
    chk("w1_wvalid_hold2", 32'(m_wvalid), 32'd1);
    chk("w1_bready_early", 32'(m_bready), 32'd0);
    tick();
    chk("w1_wvalid_hold3", 32'(m_wvalid), 32'd1);
    chk("w1_wdata_stable", m_wdata, 32'h1234_5678);
    tick();
    wready = 1'b1;
    chk("w1_wvalid_hold4", 32'(m_wvalid), 32'd1);
    tick();
    wready = 1'b0;
    chk("w1_wvalid_drop", 32'(m_wvalid), 32'd0);
    chk("w1_bready", 32'(m_bready), 32'd1);
    bvalid = 1'b1; bresp = 2'd1;
    tick();
    bvalid = 1'b0;
    chk("w1_resp_valid", 32'(m_resp_valid), 32'd1);
    chk("w1_bresp", 32'(m_resp_resp), 32'd1);
    chk("w1_bready_off", 32'(m_bready), 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    tick();
    chk("w1_single_resp", 32'(m_resp_valid), 32'd0);

    // Read with five RDATA wait cycles, then held response and back-to-back request
    arready = 1'b1;
    req(1'b0, 32'h20, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
    chk("r0_arvalid", 32'(m_arvalid), 32'd1);
    chk("r0_araddr", m_araddr, 32'h20);
    tick();
    chk("r0_arvalid_drop", 32'(m_arvalid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("r0_rready_wait", 32'(m_rready), 32'd1);
      tick();
    end
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'd2;
    tick();
    rvalid = 1'b0;
    chk("r0_resp_valid", 32'(m_resp_valid), 32'd1);
    chk("r0_rdata", m_resp_rdata, 32'hDEAD_BEEF);
    chk("r0_rresp", 32'(m_resp_resp), 32'd2);
    chk("r0_timeout", 32'(m_resp_timeout), 32'd0);
    chk("r0_rready_off", 32'(m_rready), 32'd0);
    req(1'b0, 32'h40, 32'h0, 4'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_req_ready", 32'(m_req_ready), 32'd0);
      chk("hold_resp_valid", 32'(m_resp_valid), 32'd1);
      chk("hold_rdata", m_resp_rdata, 32'hDEAD_BEEF);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("r1_ready_after_hs", 32'(m_req_ready), 32'd1);
    chk("r1_resp_cleared", 32'(m_resp_valid), 32'd0);
    rvalid = 1'b1; rdata = 32'h0BAD_F00D; rresp = 2'd1;
    tick();
    req_valid = 1'b0;
    chk("r1_accepted", 32'(m_arvalid), 32'd1);
    chk("r1_araddr", m_araddr, 32'h40);
    tick();
    tick();
    chk("r1_rdata", m_resp_rdata, 32'h0BAD_F00D);
    chk("r1_rresp", 32'(m_resp_resp), 32'd1);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0; rvalid = 1'b0; arready = 1'b0;

    // Reset while waiting for B
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
    req(1'b1, 32'h70, 32'h77, 4'hF);
    tick();
    req_valid = 1'b0;
    tick();
    chk("rw_bready_wresp", 32'(m_bready), 32'd1);
    rst_main = 1'b1;
    tick();
    chk("rw_bready_rst", 32'(m_bready), 32'd0);
    chk("rw_resp_valid_rst", 32'(m_resp_valid), 32'd0);
    chk("rw_rdata_rst", m_resp_rdata, 32'd0);
    chk("rw_resp_rst", 32'(m_resp_resp), 32'd0);
    chk("rw_awaddr_rst", m_awaddr, 32'd0);
    chk("rw_wdata_rst", m_wdata, 32'd0);
    rst_main = 1'b0; bvalid = 1'b1;
    tick();
    chk("rw_req_ready", 32'(m_req_ready), 32'd1);
    chk("rw_bready_ignored", 32'(m_bready), 32'd0);
    chk("rw_no_resp", 32'(m_resp_valid), 32'd0);
    bvalid = 1'b0; awready = 1'b0; wready = 1'b0;

    // TIMEOUT=4 instance: normal read first, then AR never accepted
    rst_main = 1'b1; rst_to = 1'b0;
    arready = 1'b1; rvalid = 1'b1; rdata = 32'hCAFE_0001; rresp = 2'd3;
    tick();
    chk("to_req_ready", 32'(t_req_ready), 32'd1);
    req(1'b0, 32'h50, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("to_r0_rdata", t_resp_rdata, 32'hCAFE_0001);
    chk("to_r0_rresp", 32'(t_resp_resp), 32'd3);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0; arready = 1'b0;
    req(1'b0, 32'h60, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
    chk("to_arvalid_w1", 32'(t_arvalid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_arvalid_wait", 32'(t_arvalid), 32'd1);
      chk("to_rready_ign", 32'(t_rready), 32'd0);
    end
    tick();
    chk("to_arvalid_drop", 32'(t_arvalid), 32'd0);
    chk("to_resp_valid", 32'(t_resp_valid), 32'd1);
    chk("to_timeout", 32'(t_resp_timeout), 32'd1);
    chk("to_rdata_zero", t_resp_rdata, 32'd0);
    chk("to_resp_zero", 32'(t_resp_resp), 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0; rvalid = 1'b0;
    chk("to_done", 32'(t_resp_valid), 32'd0);
    chk("to_idle", 32'(t_req_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
